// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding, default timing constants and counter helpers for the PLL reset sequencer.
package pll_seq_pkg;
  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_seq_state_t;
  localparam int RST_HOLD_DEF     = 100;
  localparam int LOCK_STABLE_DEF  = 1000;
  localparam int LOCK_TIMEOUT_DEF = 100000;
  localparam int EVT_W            = 8;
  function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous bit, resetting to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: drives PLL reset, qualifies lock, releases system reset and counts retries/lock losses.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD     = RST_HOLD_DEF,
  parameter int LOCK_STABLE  = LOCK_STABLE_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int CNT_W        = 20
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             locked,
  input  logic             soft_rst,
  input  logic             clear_counts,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             pll_ready,
  output logic [1:0]       state,
  output logic [EVT_W-1:0] retry_count,
  output logic [EVT_W-1:0] lol_count
);
  pll_seq_state_t st, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic locked_s, retry_inc, lol_inc;

  sync_2ff u_sync (.clk(refclk), .rst_n(rst_n), .d(locked), .q(locked_s));

  always_comb begin
    nxt = st;
    retry_inc = 1'b0;
    lol_inc = 1'b0;
    case (st)
      RESET_PLL: if (cnt == CNT_W'(RST_HOLD - 1)) nxt = WAIT_LOCK;
      WAIT_LOCK:
        if (locked_s) nxt = STABLE;
        else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          nxt = RESET_PLL;
          retry_inc = 1'b1;
        end
      STABLE:
        if (!locked_s) nxt = WAIT_LOCK;
        else if (cnt == CNT_W'(LOCK_STABLE - 1)) nxt = RUN;
      default:
        if (!locked_s) begin
          nxt = RESET_PLL;
          lol_inc = 1'b1;
        end
    endcase
    // soft_rst overrides every transition and suppresses any counted event
    if (soft_rst) begin
      nxt = RESET_PLL;
      retry_inc = 1'b0;
      lol_inc = 1'b0;
    end
    cnt_nxt = (soft_rst || nxt != st || st == RUN) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      st          <= RESET_PLL;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      pll_ready   <= 1'b0;
      retry_count <= '0;
      lol_count   <= '0;
    end else begin
      st          <= nxt;
      cnt         <= cnt_nxt;
      pll_rst     <= nxt == RESET_PLL;
      sys_rst     <= nxt != RUN;
      pll_ready   <= nxt == RUN;
      retry_count <= clear_counts ? '0 : retry_inc ? sat_inc(retry_count) : retry_count;
      lol_count   <= clear_counts ? '0 : lol_inc ? sat_inc(lol_count) : lol_count;
    end

  assign state = st;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed table vectors plus hand sequences for the PLL reset sequencer.
module tb_pll_reset_sequencer;
  logic refclk = 1'b0, rst_n = 1'b0, locked = 1'b0, soft_rst = 1'b0, clear_counts = 1'b0;
  logic pll_rst, sys_rst, pll_ready;
  logic [1:0] state;
  logic [7:0] retry_count, lol_count;
  int total = 0, bad = 0;

  typedef struct {
    logic rn, lk, sr_in, clr;
    int n;
    logic [1:0] st;
    logic pr, sr, rdy;
    logic [7:0] rc, lc;
  } vec_t;
  vec_t v[$];

  pll_reset_sequencer #(.RST_HOLD(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(32), .CNT_W(8)) dut (
    .refclk(refclk), .rst_n(rst_n), .locked(locked), .soft_rst(soft_rst),
    .clear_counts(clear_counts), .pll_rst(pll_rst), .sys_rst(sys_rst),
    .pll_ready(pll_ready), .state(state), .retry_count(retry_count), .lol_count(lol_count)
  );

  always #5 refclk = ~refclk;

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [1:0] st, input logic pr, input logic sr,
                     input logic rdy, input logic [7:0] rc, input logic [7:0] lc);
    total++;
    if ({state, pll_rst, sys_rst, pll_ready, retry_count, lol_count} !== {st, pr, sr, rdy, rc, lc}) begin
      bad++;
      $display("FAIL %s: got st=%0d pll_rst=%b sys_rst=%b rdy=%b retry=%0d lol=%0d, want st=%0d pll_rst=%b sys_rst=%b rdy=%b retry=%0d lol=%0d",
               nm, state, pll_rst, sys_rst, pll_ready, retry_count, lol_count, st, pr, sr, rdy, rc, lc);
    end
  endtask

  task automatic add(input logic rn, input logic lk, input logic s, input logic c, input int n,
                     input logic [1:0] st, input logic pr, input logic sr, input logic rdy,
                     input logic [7:0] rc, input logic [7:0] lc);
    v.push_back('{rn, lk, s, c, n, st, pr, sr, rdy, rc, lc});
  endtask

  initial begin
    // power-up with lock, release after a 4-cycle hold and 8 stable cycles
    add(0, 1, 0, 0, 2, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, 0, 3, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 1, 2, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 7, 2, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 1, 3, 0, 0, 1, 0, 0);
    // loss of lock in RUN for 5 cycles, then full re-sequence
    add(1, 0, 0, 0, 2, 3, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1);
    add(1, 0, 0, 0, 2, 0, 1, 1, 0, 0, 1);
    add(1, 1, 0, 0, 2, 1, 0, 1, 0, 0, 1);
    add(1, 1, 0, 0, 1, 2, 0, 1, 0, 0, 1);
    add(1, 1, 0, 0, 8, 3, 0, 0, 1, 0, 1);
    // lock dropout while STABLE at cnt=5
    add(0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, 0, 5, 2, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 5, 2, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 2, 2, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 1, 2, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 7, 2, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 1, 3, 0, 0, 1, 0, 0);
    // no lock: timeouts every 36 cycles, saturating at 255
    add(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 35, 1, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1, 1, 0, 1, 0);
    add(1, 0, 0, 0, 9144, 0, 1, 1, 0, 255, 0);
    add(1, 0, 0, 0, 1620, 0, 1, 1, 0, 255, 0);
    // clear_counts wins over a same-cycle timeout
    add(1, 0, 0, 0, 35, 1, 0, 1, 0, 255, 0);
    add(1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 36, 0, 1, 1, 0, 1, 0);
    // soft_rst on a timeout cycle is not counted and restarts the hold
    add(1, 0, 0, 0, 35, 1, 0, 1, 0, 1, 0);
    add(1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0);
    add(1, 0, 0, 0, 3, 0, 1, 1, 0, 1, 0);
    add(1, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0);

    foreach (v[i]) begin
      rst_n = v[i].rn;
      locked = v[i].lk;
      soft_rst = v[i].sr_in;
      clear_counts = v[i].clr;
      step(v[i].n);
      chk($sformatf("vec%0d", i), v[i].st, v[i].pr, v[i].sr, v[i].rdy, v[i].rc, v[i].lc);
    end
    soft_rst = 1'b0;
    clear_counts = 1'b0;

    // soft_rst in the cycle a RUN loss of lock is detected
    rst_n = 1'b0; locked = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(13);
    chk("soft_run_pre", 3, 0, 0, 1, 0, 0);
    locked = 1'b0;
    step(2);
    chk("soft_run_sync", 3, 0, 0, 1, 0, 0);
    soft_rst = 1'b1;
    step(1);
    soft_rst = 1'b0;
    chk("soft_vs_lol", 0, 1, 1, 0, 0, 0);
    step(1);
    chk("soft_vs_lol_after", 0, 1, 1, 0, 0, 0);

    // asynchronous reset mid-STABLE, then a full hold
    locked = 1'b1; rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(8);
    chk("mid_stable", 2, 0, 1, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 0, 1, 1, 0, 0, 0);
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("rehold_3", 0, 1, 1, 0, 0, 0);
    step(1);
    chk("rehold_4", 1, 0, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset and lock supervisor that sits on the other side of the PLL wrapper's `rst`/`locked` interface. It drives the PLL reset, watches the PLL lock indication, and only releases the downstream system reset after lock has been continuously stable. It retries on lock timeout, re-sequences on loss of lock, and exposes saturating event counters for the status register bank. It runs on the free-running 100 MHz reference clock, never on a PLL output.

## Interface
- `RST_HOLD`, default 100: cycles `pll_rst` is held high per reset attempt (1 µs).
- `LOCK_STABLE`, default 1000: cycles of continuous lock required before release.
- `LOCK_TIMEOUT`, default 100000: cycles to wait for lock before retrying (1 ms).
- `CNT_W`, default 20: width of the shared cycle counter; must cover the largest of the three above.
- `refclk  in  1`: free-running reference clock; the block's only clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `locked  in  1`: PLL lock; asynchronous to `refclk`, synchronised internally.
- `soft_rst  in  1`: single-cycle request to re-sequence the PLL.
- `clear_counts  in  1`: single-cycle clear of both event counters.
- `pll_rst  out  1`: active-high reset to the PLL.
- `sys_rst  out  1`: active-high reset to logic clocked by the PLL outputs.
- `pll_ready  out  1`: high only in RUN.
- `state  out  2`: current state encoding, for status readback.
- `retry_count  out  8`: lock timeouts; saturates at 255.
- `lol_count  out  8`: loss-of-lock events seen in RUN; saturates at 255.

## Operation
- `locked` passes through a 2-flop synchroniser to give `locked_s`; the synchroniser resets to 0.
- States (encoding): RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3. A single counter `cnt` is cleared on every state change.
- **RESET_PLL**
  - `cnt` increments each cycle.
  - When `cnt == RST_HOLD-1`, go to WAIT_LOCK.
- **WAIT_LOCK**
  - If `locked_s` is high, go to STABLE.
  - Otherwise `cnt` increments. When `cnt == LOCK_TIMEOUT-1`, go to RESET_PLL and increment `retry_count`.
- **STABLE**
  - If `locked_s` drops, return to WAIT_LOCK. This is not counted as a loss of lock.
  - Otherwise, when `cnt == LOCK_STABLE-1`, go to RUN.
- **RUN**
  - If `locked_s` drops, go to RESET_PLL and increment `lol_count`.
- **Priority**
  - `soft_rst` in any state forces RESET_PLL with `cnt` cleared, and overrides every other transition.
  - A `soft_rst` does not increment either counter, even in a cycle where a counter increment would otherwise have happened.
  - `soft_rst` in RESET_PLL restarts the hold count.
- **Counters**
  - `clear_counts` zeroes both counters.
  - `clear_counts` wins over a same-cycle increment.
  - Increments saturate at 255.
- **Outputs** (registered, decoded from next state, so they change in the same cycle as `state`):
  - `pll_rst` is high iff the state is RESET_PLL.
  - `sys_rst` is high iff the state is not RUN.
  - `pll_ready` is high iff the state is RUN.

## Timing
- **While `rst_n` is low:** `state`=RESET_PLL, `pll_rst`=1, `sys_rst`=1, `pll_ready`=0, `cnt`=0, both counters 0, synchroniser 0.
- **Reset release:** `rst_n` assertion takes effect asynchronously. Deassertion is followed by `RST_HOLD` cycles of `pll_rst`=1.
- **Lock latency:** from a `locked` rising edge to a STABLE entry is 2 cycles for synchronisation plus 1 for the register.
- **Release latency:** `sys_rst` falls `LOCK_STABLE` cycles after STABLE entry.
- **Loss-of-lock latency:** a `locked` fall during RUN raises `sys_rst` and `pll_rst` 3 cycles later.
- **`soft_rst` latency:** `pll_rst` rises on the edge after `soft_rst` is sampled.
- **Glitches:** a `locked` glitch shorter than 1 cycle may be missed. That is acceptable, because the PLL holds lock-loss for many cycles.
- **Reset mid-sequence:** `rst_n` asserted in any state returns everything to the reset values immediately.

## Structure
- Shared package `pll_seq_pkg`:
  - state enum `pll_seq_state_t`
  - default constants for `RST_HOLD`, `LOCK_STABLE` and `LOCK_TIMEOUT`
  - counter width 8
- One sub-module: `sync_2ff` (1-bit, async active-low reset to 0), used for `locked`.
- The rest is one FSM process plus counter logic in the top module.

## Test plan
All scenarios use `RST_HOLD`=4, `LOCK_STABLE`=8, `LOCK_TIMEOUT`=32.
1. `rst_n` low then high, `locked` tied high:
   - `pll_rst` high for 4 cycles;
   - `sys_rst` falls 8 cycles after STABLE entry;
   - `pll_ready`=1, `state`=3.
2. `locked` tied low:
   - after 4 hold cycles plus 32 wait cycles, `pll_rst` reasserts and `retry_count`=1;
   - after 300 attempts, `retry_count` stays at 255.
3. In RUN, drop `locked` for 5 cycles:
   - `sys_rst`=1 and `pll_rst`=1 appear 3 cycles after the drop;
   - `lol_count`=1;
   - the full sequence repeats when `locked` returns.
4. In STABLE, `locked` low for 2 cycles at `cnt`=5:
   - return to WAIT_LOCK with `lol_count` unchanged;
   - `sys_rst` is released only after a fresh 8 stable cycles.
5. `soft_rst` in RUN in the same cycle as a loss of lock is detected:
   - RESET_PLL is entered and `lol_count` is unchanged;
   - separately, `clear_counts` together with a timeout leaves `retry_count`=0.
6. `rst_n` asserted mid-STABLE:
   - all outputs immediately take their reset values;
   - after release, a full 4-cycle hold is observed.
